// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and reset constants used by cp0_ctrl and cp0_timer.
package cp0_defs;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_BEV   = 22;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] RESET_STATUS_DEFAULT = 32'h0040_0000;
  localparam int          COUNT_DIV_DEFAULT    = 2;

  function automatic logic is_exception(input logic [31:0] t);
    return (t == EXC_INT) || (t == EXC_ADEL) || (t == EXC_ADES) || (t == EXC_SYS) ||
           (t == EXC_BP) || (t == EXC_RI) || (t == EXC_OV);
  endfunction

  function automatic logic [4:0] exc_code(input logic [31:0] t);
    logic [4:0] c;
    c = CODE_INT;
    case (t)
      EXC_ADEL: c = CODE_ADEL;
      EXC_ADES: c = CODE_ADES;
      EXC_SYS:  c = CODE_SYS;
      EXC_BP:   c = CODE_BP;
      EXC_RI:   c = CODE_RI;
      EXC_OV:   c = CODE_OV;
      default:  c = CODE_INT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with the divider and the sticky timer interrupt.
module cp0_timer
  import cp0_defs::*;
#(
  parameter int COUNT_DIV = COUNT_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic [31:0] count_reg, count_next;
  logic [31:0] compare_reg, compare_next;
  logic        phase_reg, phase_next;
  logic        timer_int_reg, timer_int_next;
  logic        tick;

  always_comb begin
    tick           = (COUNT_DIV == 1) || phase_reg;
    phase_next     = (COUNT_DIV == 1) ? 1'b0 : ~phase_reg;
    count_next     = tick ? count_reg + 32'd1 : count_reg;
    compare_next   = compare_reg;
    timer_int_next = timer_int_reg;
    if ((compare_reg != 32'd0) && (count_reg == compare_reg))
      timer_int_next = 1'b1;
    if (count_we) begin
      count_next = wdata;
      phase_next = 1'b0;
    end
    // A Compare load acknowledges the interrupt even if a match lands on the same edge
    if (compare_we) begin
      compare_next   = wdata;
      timer_int_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_reg     <= 32'd0;
      compare_reg   <= 32'd0;
      phase_reg     <= 1'b0;
      timer_int_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      compare_reg   <= compare_next;
      phase_reg     <= phase_next;
      timer_int_reg <= timer_int_next;
    end
  end

  assign count     = count_reg;
  assign compare   = compare_reg;
  assign timer_int = timer_int_reg;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 architectural state: commits exceptions/ERET, services MTC0/MFC0,
// and exposes Status/Cause/EPC back to the exception encoder.
module cp0_ctrl
  import cp0_defs::*;
#(
  parameter logic [31:0] RESET_STATUS = RESET_STATUS_DEFAULT,
  parameter int          COUNT_DIV    = COUNT_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  input  logic [5:0]  int_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic        exc_valid, eret, mtc0;
  logic [7:0]  im_reg, im_next;
  logic        exl_reg, exl_next, ie_reg, ie_next;
  logic        bd_reg, bd_next;
  logic [4:0]  exc_code_reg, exc_code_next;
  logic [1:0]  ip_sw_reg, ip_sw_next;
  logic [5:0]  ip_hw_reg, ip_hw_next;
  logic [31:0] epc_reg, epc_next, badvaddr_reg, badvaddr_next;
  logic [31:0] count, compare;
  logic        timer_int;

  assign exc_valid = is_exception(excepttype_i);
  assign eret      = (excepttype_i == EXC_ERET);
  // Any exception or ERET on the same cycle squashes the whole MTC0
  assign mtc0      = we_i && !exc_valid && !eret;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .count_we  (mtc0 && (waddr_i == REG_COUNT)),
    .compare_we(mtc0 && (waddr_i == REG_COMPARE)),
    .wdata     (wdata_i),
    .count     (count),
    .compare   (compare),
    .timer_int (timer_int)
  );

  genvar gi;
  for (gi = 0; gi < 6; gi++) begin : g_ip_hw
    if (gi == 5) begin : g_timer_line
      assign ip_hw_next[gi] = int_i[gi] | timer_int;
    end else begin : g_ext_line
      assign ip_hw_next[gi] = int_i[gi];
    end
  end

  always_comb begin
    im_next       = im_reg;
    exl_next      = exl_reg;
    ie_next       = ie_reg;
    bd_next       = bd_reg;
    exc_code_next = exc_code_reg;
    ip_sw_next    = ip_sw_reg;
    epc_next      = epc_reg;
    badvaddr_next = badvaddr_reg;
    if (exc_valid) begin
      // Nested exceptions keep the original return point
      if (!exl_reg) begin
        epc_next = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        bd_next  = is_in_delayslot_i;
      end
      exl_next      = 1'b1;
      exc_code_next = exc_code(excepttype_i);
      if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES))
        badvaddr_next = bad_addr_i;
    end else if (eret) begin
      exl_next = 1'b0;
    end else if (mtc0) begin
      case (waddr_i)
        REG_STATUS: begin
          im_next  = wdata_i[STATUS_IM_HI:STATUS_IM_LO];
          exl_next = wdata_i[STATUS_EXL];
          ie_next  = wdata_i[STATUS_IE];
        end
        REG_CAUSE: ip_sw_next = wdata_i[CAUSE_IP_LO+1:CAUSE_IP_LO];
        REG_EPC:   epc_next   = wdata_i;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      im_reg       <= RESET_STATUS[STATUS_IM_HI:STATUS_IM_LO];
      exl_reg      <= RESET_STATUS[STATUS_EXL];
      ie_reg       <= RESET_STATUS[STATUS_IE];
      bd_reg       <= 1'b0;
      exc_code_reg <= 5'd0;
      ip_sw_reg    <= 2'd0;
      ip_hw_reg    <= 6'd0;
      epc_reg      <= 32'd0;
      badvaddr_reg <= 32'd0;
    end else begin
      im_reg       <= im_next;
      exl_reg      <= exl_next;
      ie_reg       <= ie_next;
      bd_reg       <= bd_next;
      exc_code_reg <= exc_code_next;
      ip_sw_reg    <= ip_sw_next;
      ip_hw_reg    <= ip_hw_next;
      epc_reg      <= epc_next;
      badvaddr_reg <= badvaddr_next;
    end
  end

  assign status_o    = {9'd0, RESET_STATUS[STATUS_BEV], 6'd0, im_reg, 6'd0, exl_reg, ie_reg};
  assign cause_o     = {bd_reg, timer_int, 14'd0, ip_hw_reg, ip_sw_reg, 1'b0, exc_code_reg, 2'b00};
  assign epc_o       = epc_reg;
  assign badvaddr_o  = badvaddr_reg;
  assign count_o     = count;
  assign compare_o   = compare;
  assign timer_int_o = timer_int;

  always_comb begin
    data_o = 32'd0;
    if (resetn) begin
      case (raddr_i)
        REG_BADVADDR: data_o = badvaddr_reg;
        REG_COUNT:    data_o = count;
        REG_COMPARE:  data_o = compare;
        REG_STATUS:   data_o = status_o;
        REG_CAUSE:    data_o = cause_o;
        REG_EPC:      data_o = epc_reg;
        default:      data_o = 32'd0;
      endcase
    end
  end

endmodule
